config_sequencer: RTL and testbench

Parametrised successor of the fixed 8-field configuration control unit. It sequences reception of N_FIELDS configuration words from the serial receiver and drives a one-hot load vector into the configuration register bank. Words that fail parity are retried up to a bounded count. It reports completion or an error code to the main controller. It sits between the serial receiver (fim_recepcao, parity_ok) and the configuration datapath.

---
 rtl/config_sequencer_if.sv | 27 ++
 rtl/config_sequencer.sv | 140 ++++++++++++++
 tb/tb_config_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/config_sequencer_if.sv
// Handshake bundle between the serial receiver/main controller and config_sequencer.
interface config_sequencer_if #(
  parameter int unsigned N_FIELDS = 8
);
  localparam int unsigned IDX_W = $clog2(N_FIELDS);

  logic                receber_config;
  logic                fim_recepcao;
  logic                parity_ok;
  logic [N_FIELDS-1:0] load;
  logic [IDX_W-1:0]    field_idx;
  logic                nack;
  logic                pronto_config;
  logic                erro_config;
  logic [1:0]          erro_code;
  logic [2:0]          db_estado;

  modport master (
    output receber_config, fim_recepcao, parity_ok,
    input  load, field_idx, nack, pronto_config, erro_config, erro_code, db_estado
  );

  modport slave (
    input  receber_config, fim_recepcao, parity_ok,
    output load, field_idx, nack, pronto_config, erro_config, erro_code, db_estado
  );
endinterface

// File: rtl/config_sequencer.sv
// Sequences N_FIELDS configuration words into one-hot loads, with bounded parity retries.
// Optional per-word receive timeout enabled by defining CONFIG_TIMEOUT_EN.
module config_sequencer #(
  parameter int unsigned N_FIELDS       = 8,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                clock,
  input logic                reset,
  config_sequencer_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(N_FIELDS);
  localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  if (N_FIELDS < 2) begin : g_chk_fields
    $error("config_sequencer: N_FIELDS must be >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("config_sequencer: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECEBE = 3'd1,
    FIM    = 3'd2,
    ERRO   = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   field_idx_q, field_idx_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               nack_q, nack_d;
  logic [1:0]         erro_code_q, erro_code_d;

`ifdef CONFIG_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  logic [TMR_W-1:0]   timer_q, timer_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      field_idx_q <= '0;
      retry_q     <= '0;
      nack_q      <= 1'b0;
      erro_code_q <= '0;
`ifdef CONFIG_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      field_idx_q <= field_idx_d;
      retry_q     <= retry_d;
      nack_q      <= nack_d;
      erro_code_q <= erro_code_d;
`ifdef CONFIG_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    field_idx_d = field_idx_q;
    retry_d     = retry_q;
    nack_d      = 1'b0;
    erro_code_d = erro_code_q;
`ifdef CONFIG_TIMEOUT_EN
    timer_d     = timer_q;
`endif

    case (state_q)
      IDLE, ERRO: begin
        if (bus.receber_config) begin
          state_d     = RECEBE;
          field_idx_d = '0;
          retry_d     = '0;
          erro_code_d = 2'd0;
`ifdef CONFIG_TIMEOUT_EN
          timer_d     = '0;
`endif
        end
      end

      RECEBE: begin
`ifdef CONFIG_TIMEOUT_EN
        timer_d = timer_q + TMR_W'(1);
`endif
        if (bus.fim_recepcao) begin
`ifdef CONFIG_TIMEOUT_EN
          timer_d = '0;
`endif
          if (bus.parity_ok) begin
            retry_d = '0;
            if (field_idx_q == IDX_W'(N_FIELDS - 1)) begin
              state_d     = FIM;
              erro_code_d = 2'd0;
            end else begin
              field_idx_d = field_idx_q + IDX_W'(1);
            end
          end else if (retry_q < RTY_W'(MAX_RETRIES)) begin
            retry_d = retry_q + RTY_W'(1);
            nack_d  = 1'b1;
          end else begin
            state_d     = ERRO;
            erro_code_d = 2'd1;
          end
        end
`ifdef CONFIG_TIMEOUT_EN
        // A strobe in the final timer cycle wins over the timeout.
        else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ERRO;
          erro_code_d = 2'd2;
        end
`endif
      end

      FIM: begin
        state_d     = IDLE;
        erro_code_d = 2'd0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.load = '0;
    if (state_q == RECEBE) begin
      bus.load[field_idx_q] = 1'b1;
    end
  end

  assign bus.field_idx     = field_idx_q;
  assign bus.nack          = nack_q;
  assign bus.pronto_config = (state_q == FIM) || (state_q == ERRO);
  assign bus.erro_config   = (state_q == ERRO);
  assign bus.erro_code     = erro_code_q;
  assign bus.db_estado     = state_q;
endmodule

// File: tb/tb_config_sequencer.sv
// Directed-vector bench for config_sequencer (N_FIELDS=8, MAX_RETRIES=2, TIMEOUT_CYCLES=16).
module tb_config_sequencer;
  localparam int unsigned N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  config_sequencer_if #(.N_FIELDS(N)) cfg ();

  config_sequencer #(
    .N_FIELDS(N),
    .MAX_RETRIES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(cfg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic start_frame();
    cfg.receber_config = 1'b1;
    step();
    cfg.receber_config = 1'b0;
  endtask

  task automatic send_word(input logic ok);
    cfg.fim_recepcao = 1'b1;
    cfg.parity_ok    = ok;
    step();
    cfg.fim_recepcao = 1'b0;
    cfg.parity_ok    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    cfg.receber_config = 1'b0;
    cfg.fim_recepcao   = 1'b0;
    cfg.parity_ok      = 1'b0;
    step(2);
    check("rst_state", 32'(cfg.db_estado), 32'd0);
    check("rst_load", 32'(cfg.load), 32'd0);
    check("rst_idx", 32'(cfg.field_idx), 32'd0);
    check("rst_pronto", 32'(cfg.pronto_config), 32'd0);
    check("rst_erro", 32'(cfg.erro_config), 32'd0);
    check("rst_code", 32'(cfg.erro_code), 32'd0);
    check("rst_nack", 32'(cfg.nack), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_hold", 32'(cfg.db_estado), 32'd0);

    // Full frame, words spaced 5 cycles apart.
    start_frame();
    for (int i = 0; i < 8; i++) begin
      check("t1_load", 32'(cfg.load), 32'd1 << i);
      check("t1_idx", 32'(cfg.field_idx), 32'(i));
      step(4);
      send_word(1'b1);
    end
    check("t1_fim_state", 32'(cfg.db_estado), 32'd2);
    check("t1_pronto", 32'(cfg.pronto_config), 32'd1);
    check("t1_erro", 32'(cfg.erro_config), 32'd0);
    check("t1_fim_load", 32'(cfg.load), 32'd0);
    step();
    check("t1_pronto_off", 32'(cfg.pronto_config), 32'd0);
    check("t1_idle", 32'(cfg.db_estado), 32'd0);

    // Two parity retries on field 3, then success.
    start_frame();
    repeat (3) send_word(1'b1);
    check("t2_idx3", 32'(cfg.field_idx), 32'd3);
    send_word(1'b0);
    check("t2_nack1", 32'(cfg.nack), 32'd1);
    check("t2_idx_hold", 32'(cfg.field_idx), 32'd3);
    check("t2_state", 32'(cfg.db_estado), 32'd1);
    step();
    check("t2_nack_pulse", 32'(cfg.nack), 32'd0);
    send_word(1'b0);
    check("t2_nack2", 32'(cfg.nack), 32'd1);
    check("t2_idx_hold2", 32'(cfg.field_idx), 32'd3);
    send_word(1'b1);
    check("t2_nack_clr", 32'(cfg.nack), 32'd0);
    check("t2_idx4", 32'(cfg.field_idx), 32'd4);
    repeat (4) send_word(1'b1);
    check("t2_fim", 32'(cfg.db_estado), 32'd2);
    check("t2_code", 32'(cfg.erro_code), 32'd0);
    check("t2_erro", 32'(cfg.erro_config), 32'd0);
    step();

    // Retries exhausted on field 0.
    start_frame();
    send_word(1'b0);
    check("t3_nack1", 32'(cfg.nack), 32'd1);
    send_word(1'b0);
    check("t3_nack2", 32'(cfg.nack), 32'd1);
    send_word(1'b0);
    check("t3_erro_state", 32'(cfg.db_estado), 32'd3);
    check("t3_pronto", 32'(cfg.pronto_config), 32'd1);
    check("t3_erro", 32'(cfg.erro_config), 32'd1);
    check("t3_code", 32'(cfg.erro_code), 32'd1);
    check("t3_nack_none", 32'(cfg.nack), 32'd0);
    check("t3_load", 32'(cfg.load), 32'd0);
    step(3);
    check("t3_hold_state", 32'(cfg.db_estado), 32'd3);
    check("t3_hold_code", 32'(cfg.erro_code), 32'd1);
    start_frame();
    check("t3_restart", 32'(cfg.db_estado), 32'd1);
    check("t3_restart_idx", 32'(cfg.field_idx), 32'd0);
    check("t3_restart_code", 32'(cfg.erro_code), 32'd0);
    check("t3_restart_erro", 32'(cfg.erro_config), 32'd0);
    check("t3_restart_pronto", 32'(cfg.pronto_config), 32'd0);

    // Asynchronous reset mid-frame at field 5.
    repeat (5) send_word(1'b1);
    check("t4_idx5", 32'(cfg.field_idx), 32'd5);
    check("t4_load5", 32'(cfg.load), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_state", 32'(cfg.db_estado), 32'd0);
    check("t4_async_load", 32'(cfg.load), 32'd0);
    check("t4_async_idx", 32'(cfg.field_idx), 32'd0);
    step();
    rst_n = 1'b1;
    step(2);
    check("t4_idle", 32'(cfg.db_estado), 32'd0);
    start_frame();
    check("t4_fresh_idx", 32'(cfg.field_idx), 32'd0);
    check("t4_fresh_load", 32'(cfg.load), 32'd1);

    // receber_config ignored mid-frame.
    repeat (2) send_word(1'b1);
    check("t5_idx2", 32'(cfg.field_idx), 32'd2);
    cfg.receber_config = 1'b1;
    step();
    cfg.receber_config = 1'b0;
    check("t5_ignore_idx", 32'(cfg.field_idx), 32'd2);
    check("t5_ignore_state", 32'(cfg.db_estado), 32'd1);
    step();
    check("t5_ignore_idx2", 32'(cfg.field_idx), 32'd2);

`ifdef CONFIG_TIMEOUT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    start_frame();
    step(15);
    check("t6_pre_timeout", 32'(cfg.db_estado), 32'd1);
    step();
    check("t6_timeout_state", 32'(cfg.db_estado), 32'd3);
    check("t6_timeout_code", 32'(cfg.erro_code), 32'd2);
    check("t6_timeout_erro", 32'(cfg.erro_config), 32'd1);
    start_frame();
    step(15);
    send_word(1'b1);
    check("t6_late_idx", 32'(cfg.field_idx), 32'd1);
    check("t6_late_state", 32'(cfg.db_estado), 32'd1);
    check("t6_late_code", 32'(cfg.erro_code), 32'd0);
`else
    step(40);
    check("t6_no_timeout", 32'(cfg.db_estado), 32'd1);
    check("t6_no_timeout_code", 32'(cfg.erro_code), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
